hs2_sync_fifo: RTL and testbench

- Clocked sink for a 2-phase (transition-signalled) bundled-data channel, such as the output channel of the 2-to-1 handshake mux.
- Each req toggle carries one DW-bit word. The block synchronizes req into the clk domain, captures the word into a small FIFO, and answers with an ack toggle.
- It presents the words to clocked logic on a valid/ready interface.
- Backpressure: ack is withheld while the FIFO is full.

---
 rtl/hs2_sync_fifo.sv | 107 ++++++++++
 tb/tb_hs2_sync_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs2_sync_fifo.sv
// hs2_sync_fifo: clocked sink for a 2-phase bundled-data channel.
// Each l_req transition is synchronized into clk, its word is written into a
// small FIFO and answered with an l_ack transition. The ack is held back while
// the FIFO is full, which stalls upstream without losing data. Words leave on a
// valid/ready interface.
module hs2_sync_fifo #(
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       l_req,
  output logic                       l_ack,
  input  logic [DW-1:0]              l_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_seen_q;
  logic [AW-1:0]          wptr_q;
  logic [AW-1:0]          rptr_q;
  logic [CW-1:0]          count_q;
  logic [DW-1:0]          mem_q [DEPTH];

  logic pending;
  logic full;
  logic wr_en;
  logic rd_en;

  // Synchronizer chain: only l_req crosses; l_data is held stable by upstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], l_req};
    end
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_s ^ req_seen_q;
  // Full is judged on the occupancy at the start of the cycle, so a read in
  // the same cycle never lets the write through until the next edge.
  assign full    = (count_q == FullCount);
  assign wr_en   = pending & ~full;
  assign rd_en   = out_valid & out_ready;

  // Handshake phase: consume the event and answer with an ack toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_seen_q <= 1'b0;
      l_ack      <= 1'b0;
    end else if (wr_en) begin
      req_seen_q <= req_s;
      l_ack      <= ~l_ack;
    end
  end

  // Storage and write pointer; every entry is cleared so out_data is 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
    end else if (wr_en) begin
      mem_q[wptr_q] <= l_data;
      wptr_q        <= wptr_q + AW'(1);
    end
  end

  // Read pointer advances only on an accepted read; DEPTH is a power of two so
  // the natural wrap of the AW-bit pointer is modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
    end else if (rd_en) begin
      rptr_q <= rptr_q + AW'(1);
    end
  end

  // Occupancy decides full/empty since the pointers carry no wrap bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign count     = count_q;

endmodule

// File: tb/tb_hs2_sync_fifo.sv
// Bench for hs2_sync_fifo: directed handshake/corner sequences, a table of
// stream words, and a randomized run scored against a queue model.
module tb_hs2_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic          clk;
  logic          rst;
  logic          l_req;
  logic          l_ack;
  logic [DW-1:0] l_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    count;

  hs2_sync_fifo #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .l_req     (l_req),
    .l_ack     (l_ack),
    .l_data    (l_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout_exp;
  } vec_t;

  vec_t       tbl [10];
  int         checks;
  int         errors;
  int         edges;
  int         max_count;
  int         age;
  int         max_age;
  int         size_before;
  logic       ph;
  logic       outstanding;
  logic       prev_ack;
  logic       prev_ready;
  logic [7:0] word;
  logic [7:0] tmp;
  logic [7:0] collected [$];
  logic [7:0] model_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: present a word and signal it with a req transition.
  task automatic send(input logic [7:0] d);
    l_data = d;
    l_req  = ~l_req;
  endtask

  // Bounded wait (in clock edges) until the outstanding request is acked.
  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (l_ack !== l_req && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("ack_wait", l_ack, l_req);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    l_req     = 1'b0;
    l_data    = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tbl[i].din      = 8'(i);
      tbl[i].dout_exp = 8'(i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_ack", l_ack, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single word and req->ack latency
    send(8'hA5);
    wait_ack(20, edges);
    chk("latency", edges, SYNC + 1);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_count", count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("single_drained", count, 0);

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      wait_ack(20, edges);
    end
    chk("fill_count", count, 4);
    send(8'h05);
    repeat (8) @(negedge clk);
    chk("full_no_ack", l_ack, !l_req);
    chk("full_count", count, 4);
    chk("full_head", out_data, 8'h01);
    // Read while full with a pending req: write waits one more edge
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rd_edge_count", count, 3);
    chk("rd_edge_no_ack", l_ack, !l_req);
    chk("rd_edge_head", out_data, 8'h02);
    @(negedge clk);
    chk("late_wr_count", count, 4);
    chk("late_wr_ack", l_ack, l_req);
    @(negedge clk);
    chk("ack_once", l_ack, l_req);
    chk("late_wr_hold", count, 4);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("drain_order", out_data, 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_empty", count, 0);

    // Stream of 10 words with out_ready toggling, from the table
    collected.delete();
    max_count = 0;
    ph        = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(tbl[i].din);
          wait_ack(40, edges);
        end
      end
      begin
        for (int cyc = 0; cyc < 400 && collected.size() < 10; cyc++) begin
          @(negedge clk);
          if (int'(count) > max_count) max_count = int'(count);
          out_ready = ph;
          ph        = ~ph;
          if (out_valid && out_ready) collected.push_back(out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    chk("stream_len", collected.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < collected.size()) chk("stream_word", collected[i], tbl[i].dout_exp);
    end
    chk("stream_max_count_ok", max_count <= DEPTH, 1);
    chk("stream_count", count, 0);
    chk("stream_valid", out_valid, 0);

    // Empty read is ignored
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("empty_count", count, 0);
      chk("empty_valid", out_valid, 0);
    end
    out_ready = 1'b0;
    send(8'h77);
    wait_ack(20, edges);
    chk("after_empty_data", out_data, 8'h77);
    chk("after_empty_count", count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-operation with a pending request
    send(8'h11);
    wait_ack(20, edges);
    send(8'h22);
    wait_ack(20, edges);
    send(8'h33);
    wait_ack(20, edges);
    chk("pre_rst_count", count, 3);
    send(8'h44);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ack", l_ack, 0);
    chk("mid_rst_count", count, 0);
    l_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_ack", l_ack, 0);
    chk("post_rst_count", count, 0);
    send(8'h3C);
    wait_ack(20, edges);
    chk("post_rst_data", out_data, 8'h3C);
    chk("post_rst_cnt1", count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_rst_drained", count, 0);

    // Randomized traffic against a queue model
    model_q.delete();
    prev_ack    = l_ack;
    prev_ready  = 1'b0;
    outstanding = 1'b0;
    age         = 0;
    max_age     = 0;
    word        = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      size_before = model_q.size();
      if (prev_ready && size_before != 0) tmp = model_q.pop_front();
      if (l_ack !== prev_ack) begin
        // An ack is legal only for an outstanding word and a non-full FIFO.
        chk("rnd_ack_legal", {30'd0, outstanding, size_before < DEPTH}, 32'd3);
        model_q.push_back(word);
        outstanding = 1'b0;
        prev_ack    = l_ack;
        age         = 0;
      end
      if (outstanding) begin
        age++;
        if (age > max_age) max_age = age;
      end
      chk("rnd_count", count, model_q.size());
      chk("rnd_valid", out_valid, model_q.size() != 0);
      if (model_q.size() != 0) chk("rnd_data", out_data, model_q[0]);
      if (cyc < 330 && !outstanding && $urandom_range(0, 2) == 0) begin
        word        = 8'($urandom);
        outstanding = 1'b1;
        send(word);
      end
      out_ready  = (cyc >= 330) ? 1'b1 : 1'($urandom_range(0, 1));
      prev_ready = out_ready;
    end
    out_ready = 1'b0;
    chk("rnd_outstanding", outstanding, 0);
    chk("rnd_model_empty", model_q.size(), 0);
    chk("rnd_final_count", count, 0);
    chk("rnd_max_wait_ok", max_age < 64, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
